// File: rtl/mux_arb_pkg.sv
// Shared flit-type codes, port width, enable levels and arbiter state encoding
// for the 2:1 wormhole router mux and its arbiter.
package mux_arb_pkg;

  localparam int TYPEW = 2;
  localparam int PORTW = 1;

  localparam logic [TYPEW-1:0] TYPE_NONE = 2'd0;
  localparam logic [TYPEW-1:0] TYPE_HEAD = 2'd1;
  localparam logic [TYPEW-1:0] TYPE_DATA = 2'd2;
  localparam logic [TYPEW-1:0] TYPE_TAIL = 2'd3;

  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  // Encoding doubles as the one-hot mux select.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } arb_state_e;

  // DATA or TAIL: only legal inside a packet.
  function automatic logic is_body(input logic [TYPEW-1:0] t);
    return (t == TYPE_DATA) || (t == TYPE_TAIL);
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick2.sv
// Combinational two-request round-robin picker; rr_i names the port that wins
// a tie. Output is one-hot or zero.
module mux_arb_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~rr_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] |  rr_i);

endmodule

// File: rtl/mux_arb.sv
// Two-input wormhole arbiter: locks a port from HEAD until its TAIL is accepted,
// drives the one-hot mux select, counts packets and flags protocol errors.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ordy,
  output logic [1:0]       sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic             err
);

  arb_state_e       state_q, state_d;
  logic [PORTW-1:0] rr_q, rr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             head_q, head_d;

  logic [1:0]       req;
  logic [1:0]       pick;
  logic             lk_port;
  logic             lk_valid;
  logic             lk_grant;
  logic [TYPEW-1:0] lk_type;

  assign req[0] = ivalid_0 && (itype_0 == TYPE_HEAD);
  assign req[1] = ivalid_1 && (itype_1 == TYPE_HEAD);

  mux_arb_rr_pick2 u_pick (
    .req_i (req),
    .rr_i  (rr_q),
    .gnt_o (pick)
  );

  assign lk_port  = (state_q == ST_LOCK1);
  assign lk_valid = lk_port ? ivalid_1 : ivalid_0;
  assign lk_type  = lk_port ? itype_1  : itype_0;
  assign lk_grant = lk_port ? grant_1  : grant_0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= DISABLE;
      head_q  <= DISABLE;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      head_q  <= head_d;
    end
  end

  // head_q marks that the locking HEAD was already consumed, so only a
  // second granted HEAD inside the same lock counts as an error.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    head_d  = head_q;
    case (state_q)
      ST_IDLE: begin
        if ((ivalid_0 && is_body(itype_0)) || (ivalid_1 && is_body(itype_1)))
          err_d = ENABLE;
        head_d = DISABLE;
        if (pick[0])      state_d = ST_LOCK0;
        else if (pick[1]) state_d = ST_LOCK1;
      end
      ST_LOCK0, ST_LOCK1: begin
        if (lk_valid && (lk_type == TYPE_NONE))
          err_d = ENABLE;
        if (lk_grant) begin
          head_d = ENABLE;
          if ((lk_type == TYPE_HEAD) && head_q)
            err_d = ENABLE;
          if (lk_type == TYPE_TAIL) begin
            state_d = ST_IDLE;
            rr_d    = PORTW'(~lk_port);
            cnt_d   = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel = 2'b00;
    case (state_q)
      ST_LOCK0: sel = 2'b01;
      ST_LOCK1: sel = 2'b10;
      default:  sel = 2'b00;
    endcase
  end

  assign grant_0 = sel[0] & ordy & ivalid_0;
  assign grant_1 = sel[1] & ordy & ivalid_1;
  assign pkt_cnt = cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: a CNTW=16 instance and a CNTW=4 instance share
// the same stimulus so the counter wrap can be observed on the narrow one.
module tb_mux_arb;
  import mux_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic             ivalid_0 = 1'b0;
  logic [TYPEW-1:0] itype_0 = TYPE_NONE;
  logic             ivalid_1 = 1'b0;
  logic [TYPEW-1:0] itype_1 = TYPE_NONE;
  logic             ordy = 1'b0;

  logic [1:0]  sel;
  logic        grant_0, grant_1;
  logic [15:0] pkt_cnt;
  logic        err;

  logic [1:0]  sel4;
  logic        grant4_0, grant4_1;
  logic [3:0]  pkt_cnt4;
  logic        err4;

  int n_tests = 0;
  int n_fail  = 0;

  mux_arb #(.CNTW(16)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel), .grant_0(grant_0), .grant_1(grant_1),
    .pkt_cnt(pkt_cnt), .err(err)
  );

  mux_arb #(.CNTW(4)) dut4 (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel4), .grant_0(grant4_0), .grant_1(grant4_1),
    .pkt_cnt(pkt_cnt4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [TYPEW-1:0] t0,
                       input logic v1, input logic [TYPEW-1:0] t1, input logic r);
    ivalid_0 = v0; itype_0 = t0;
    ivalid_1 = v1; itype_1 = t1;
    ordy     = r;
  endtask

  task automatic do_reset();
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    rst_ = 1'b0;
    #2;
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, TYPE_DATA, 1'b1, TYPE_HEAD, 1'b1);
    #1 rst_ = 1'b0;
    #2;
    if (sel !== 2'b00) begin $display("FAIL reset_sel got %b exp 00", sel); n_fail++; end
    n_tests++;
    if ({grant_0, grant_1} !== 2'b00) begin $display("FAIL reset_grant got %b exp 00", {grant_0, grant_1}); n_fail++; end
    n_tests++;
    if (pkt_cnt !== 16'd0) begin $display("FAIL reset_cnt got %0d exp 0", pkt_cnt); n_fail++; end
    n_tests++;
    if (err !== 1'b0) begin $display("FAIL reset_err got %b exp 0", err); n_fail++; end
    n_tests++;
    do_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_pkt();
    logic [TYPEW-1:0] t;
    int gcnt = 0;
    do_reset();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_HEAD, 1'b1);
    @(negedge clk);
    if (sel !== 2'b00 || grant_1 !== 1'b0) begin
      $display("FAIL single_idle got sel=%b g1=%b exp sel=00 g1=0", sel, grant_1); n_fail++;
    end
    n_tests++;
    tick();
    for (int k = 0; k < 22; k++) begin
      t = (k == 0) ? TYPE_HEAD : ((k == 21) ? TYPE_TAIL : TYPE_DATA);
      drive(1'b0, TYPE_NONE, 1'b1, t, 1'b1);
      @(negedge clk);
      if (k == 0) begin
        if (sel !== 2'b10) begin $display("FAIL single_lock got sel=%b exp 10", sel); n_fail++; end
        n_tests++;
      end
      if (grant_1 === 1'b1) gcnt++;
      tick();
    end
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    if (gcnt != 22) begin $display("FAIL single_grants got %0d exp 22", gcnt); n_fail++; end
    n_tests++;
    if (sel !== 2'b00) begin $display("FAIL single_release got sel=%b exp 00", sel); n_fail++; end
    n_tests++;
    if (pkt_cnt !== 16'd1) begin $display("FAIL single_cnt got %0d exp 1", pkt_cnt); n_fail++; end
    n_tests++;
    if (err !== 1'b0) begin $display("FAIL single_err got %b exp 0", err); n_fail++; end
    n_tests++;
    $display("[TB] test_single_pkt grants=%0d cnt=%0d", gcnt, pkt_cnt);
  endtask

  task automatic test_both_heads();
    do_reset();
    drive(1'b1, TYPE_HEAD, 1'b1, TYPE_HEAD, 1'b1);
    tick();
    @(negedge clk);
    if (sel !== 2'b01 || grant_0 !== 1'b1 || grant_1 !== 1'b0) begin
      $display("FAIL both_first got sel=%b g=%b%b exp sel=01 g=01", sel, grant_1, grant_0); n_fail++;
    end
    n_tests++;
    tick();
    drive(1'b1, TYPE_TAIL, 1'b1, TYPE_HEAD, 1'b1);
    @(negedge clk);
    if (grant_0 !== 1'b1 || grant_1 !== 1'b0) begin
      $display("FAIL both_tail0 got g=%b%b exp 01", grant_1, grant_0); n_fail++;
    end
    n_tests++;
    tick();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_HEAD, 1'b1);
    @(negedge clk);
    if (sel !== 2'b00 || grant_1 !== 1'b0) begin
      $display("FAIL both_bubble got sel=%b g1=%b exp sel=00 g1=0", sel, grant_1); n_fail++;
    end
    n_tests++;
    tick();
    @(negedge clk);
    if (sel !== 2'b10 || grant_1 !== 1'b1) begin
      $display("FAIL both_second got sel=%b g1=%b exp sel=10 g1=1", sel, grant_1); n_fail++;
    end
    n_tests++;
    tick();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_TAIL, 1'b1);
    tick();
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    if (pkt_cnt !== 16'd2 || sel !== 2'b00) begin
      $display("FAIL both_end got cnt=%0d sel=%b exp cnt=2 sel=00", pkt_cnt, sel); n_fail++;
    end
    n_tests++;
    $display("[TB] test_both_heads cnt=%0d", pkt_cnt);
  endtask

  task automatic test_ordy_stall();
    int gcnt = 0;
    do_reset();
    drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b1);
    tick();
    @(negedge clk); if (grant_0 === 1'b1) gcnt++;
    tick();
    drive(1'b1, TYPE_DATA, 1'b0, TYPE_NONE, 1'b1);
    @(negedge clk); if (grant_0 === 1'b1) gcnt++;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, TYPE_DATA, 1'b0, TYPE_NONE, 1'b0);
      @(negedge clk);
      if (grant_0 !== 1'b0 || sel !== 2'b01) begin
        $display("FAIL stall_%0d got g0=%b sel=%b exp g0=0 sel=01", k, grant_0, sel); n_fail++;
      end
      n_tests++;
      tick();
    end
    drive(1'b1, TYPE_DATA, 1'b0, TYPE_NONE, 1'b1);
    @(negedge clk); if (grant_0 === 1'b1) gcnt++;
    tick();
    drive(1'b1, TYPE_TAIL, 1'b0, TYPE_NONE, 1'b0);
    tick();
    if (sel !== 2'b01 || pkt_cnt !== 16'd0) begin
      $display("FAIL stall_tail_hold got sel=%b cnt=%0d exp sel=01 cnt=0", sel, pkt_cnt); n_fail++;
    end
    n_tests++;
    drive(1'b1, TYPE_TAIL, 1'b0, TYPE_NONE, 1'b1);
    @(negedge clk); if (grant_0 === 1'b1) gcnt++;
    tick();
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    if (gcnt != 4 || pkt_cnt !== 16'd1 || sel !== 2'b00 || err !== 1'b0) begin
      $display("FAIL stall_end got grants=%0d cnt=%0d sel=%b err=%b exp 4 1 00 0", gcnt, pkt_cnt, sel, err);
      n_fail++;
    end
    n_tests++;
    $display("[TB] test_ordy_stall grants=%0d", gcnt);
  endtask

  task automatic test_back_to_back();
    logic ptr0 = 1'b0, ptr1 = 1'b0;
    logic exp_port = 1'b0;
    int heads = 0;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, ptr0 ? TYPE_TAIL : TYPE_HEAD, 1'b1, ptr1 ? TYPE_TAIL : TYPE_HEAD, 1'b1);
      @(negedge clk);
      if (grant_0 === 1'b1 && grant_1 === 1'b1) begin
        $display("FAIL b2b_dual_grant cycle %0d got 11 exp one-hot", c); n_fail++;
      end
      if (grant_0 === 1'b1 && !ptr0) begin
        if (exp_port !== 1'b0) begin $display("FAIL b2b_order head %0d got port 0 exp port 1", heads); n_fail++; end
        n_tests++; heads++; exp_port = ~exp_port;
      end
      if (grant_1 === 1'b1 && !ptr1) begin
        if (exp_port !== 1'b1) begin $display("FAIL b2b_order head %0d got port 1 exp port 0", heads); n_fail++; end
        n_tests++; heads++; exp_port = ~exp_port;
      end
      if (grant_0 === 1'b1) ptr0 = ~ptr0;
      if (grant_1 === 1'b1) ptr1 = ~ptr1;
      tick();
    end
    if (heads != 4 || pkt_cnt !== 16'd4) begin
      $display("FAIL b2b_count got heads=%0d cnt=%0d exp 4 4", heads, pkt_cnt); n_fail++;
    end
    n_tests++;
    $display("[TB] test_back_to_back heads=%0d cnt=%0d", heads, pkt_cnt);
  endtask

  task automatic test_err_idle();
    do_reset();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_DATA, 1'b1);
    @(negedge clk);
    if (grant_1 !== 1'b0 || err !== 1'b0) begin
      $display("FAIL erridle_pre got g1=%b err=%b exp 0 0", grant_1, err); n_fail++;
    end
    n_tests++;
    tick();
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    if (err !== 1'b1 || sel !== 2'b00) begin
      $display("FAIL erridle_set got err=%b sel=%b exp 1 00", err, sel); n_fail++;
    end
    n_tests++;
    for (int k = 0; k < 10; k++) tick();
    if (err !== 1'b1 || sel !== 2'b00) begin
      $display("FAIL erridle_sticky got err=%b sel=%b exp 1 00", err, sel); n_fail++;
    end
    n_tests++;
    $display("[TB] test_err_idle err=%b", err);
  endtask

  task automatic test_err_lock();
    do_reset();
    drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b1);
    tick();
    tick();
    if (err !== 1'b0) begin $display("FAIL errlock_first_head got err=%b exp 0", err); n_fail++; end
    n_tests++;
    tick();
    if (err !== 1'b1) begin $display("FAIL errlock_second_head got err=%b exp 1", err); n_fail++; end
    n_tests++;
    do_reset();
    drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b0);
    tick();
    drive(1'b1, TYPE_NONE, 1'b0, TYPE_NONE, 1'b0);
    tick();
    if (err !== 1'b1 || sel !== 2'b01) begin
      $display("FAIL errlock_none got err=%b sel=%b exp 1 01", err, sel); n_fail++;
    end
    n_tests++;
    $display("[TB] test_err_lock err=%b", err);
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_DATA, 1'b1);
    tick();
    drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b1);
    tick(); tick();
    drive(1'b1, TYPE_TAIL, 1'b0, TYPE_NONE, 1'b1);
    tick();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_HEAD, 1'b1);
    tick(); tick();
    drive(1'b0, TYPE_NONE, 1'b1, TYPE_DATA, 1'b1);
    @(negedge clk);
    if (sel !== 2'b10 || pkt_cnt !== 16'd1 || err !== 1'b1) begin
      $display("FAIL arst_pre got sel=%b cnt=%0d err=%b exp 10 1 1", sel, pkt_cnt, err); n_fail++;
    end
    n_tests++;
    rst_ = 1'b0;
    #1;
    if (sel !== 2'b00 || pkt_cnt !== 16'd0 || err !== 1'b0 || grant_1 !== 1'b0) begin
      $display("FAIL arst_now got sel=%b cnt=%0d err=%b g1=%b exp 00 0 0 0", sel, pkt_cnt, err, grant_1);
      n_fail++;
    end
    n_tests++;
    #1;
    rst_ = 1'b1;
    drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b1);
    tick();
    if (sel !== 2'b01) begin $display("FAIL arst_relock got sel=%b exp 01", sel); n_fail++; end
    n_tests++;
    $display("[TB] test_async_reset sel=%b", sel);
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, TYPE_HEAD, 1'b0, TYPE_NONE, 1'b1);
      tick(); tick();
      drive(1'b1, TYPE_TAIL, 1'b0, TYPE_NONE, 1'b1);
      tick();
    end
    drive(1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1);
    if (pkt_cnt4 !== 4'd1) begin $display("FAIL wrap_cnt4 got %0d exp 1", pkt_cnt4); n_fail++; end
    n_tests++;
    if (pkt_cnt !== 16'd17) begin $display("FAIL wrap_cnt16 got %0d exp 17", pkt_cnt); n_fail++; end
    n_tests++;
    if (sel4 !== 2'b00 || err4 !== 1'b0) begin
      $display("FAIL wrap_state got sel=%b err=%b exp 00 0", sel4, err4); n_fail++;
    end
    n_tests++;
    $display("[TB] test_cnt_wrap cnt4=%0d cnt16=%0d", pkt_cnt4, pkt_cnt);
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_both_heads();
    test_ordy_stall();
    test_back_to_back();
    test_err_idle();
    test_err_lock();
    test_async_reset();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
# mux_arb

Two-input wormhole arbiter that generates the one-hot `sel` for the 2:1 router `mux`, sitting directly upstream of its select pin. It watches the valid/flit-type of both input ports, grants one port on a HEAD flit, and holds that grant until the same port's TAIL flit is accepted downstream. The mux routes the granted input to port 0. Fairness between requesters is round-robin. A packet counter and a protocol-error flag support energy and characterization runs.

## Interface
- `CNTW`, 16: width of the completed-packet counter.
- `clk`  in  1  system clock, rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `ivalid_0`  in  1  input 0 holds a valid flit.
- `itype_0`  in  `TYPEW`  flit type of input 0, i.e. the top bits of `idata_0`.
- `ivalid_1`  in  1  input 1 holds a valid flit.
- `itype_1`  in  `TYPEW`  flit type of input 1.
- `ordy`  in  1  downstream link accepts a flit this cycle.
- `sel`  out  2  one-hot mux select, registered. 2'b01 selects input 0, 2'b10 selects input 1, 2'b00 selects none.
- `grant_0`  out  1  flit on input 0 is consumed at this edge.
- `grant_1`  out  1  flit on input 1 is consumed at this edge.
- `pkt_cnt`  out  `CNTW`  count of completed packets (TAIL accepted). Wraps modulo 2^CNTW.
- `err`  out  1  sticky protocol-error flag.

## Operation
- States:
  - IDLE: `sel`=00.
  - LOCK0: `sel`=01.
  - LOCK1: `sel`=10.
- Request definition: port x requests when `ivalid_x`=1 and `itype_x`=TYPE_HEAD.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one port requests: go to LOCK of that port.
- IDLE, both ports request: grant the port named by round-robin pointer `rr`. `rr` resets to 0.
- Grant outputs: `grant_x` = `sel[x]` & `ordy` & `ivalid_x`. This is combinational from registered `sel`.
- LOCKx, granted flit of type TAIL: return to IDLE, set `rr` to the other port, increment `pkt_cnt`.
- LOCKx, HEAD, DATA or NONE flits: stay in LOCKx.
- LOCKx, `ivalid_x`=0 (bubble in the packet): stay in LOCKx with no grant. Wormhole holds the link.
- The other port's HEAD while in LOCKx: no grant. It waits.
- `err` is set, and stays set until reset, on any of these:
  - a granted flit of type HEAD while in LOCKx (the head is already consumed);
  - a valid DATA or TAIL flit on either port while in IDLE;
  - `ivalid`=1 with type TYPE_NONE on the locked port.
- Error flits in IDLE are not granted. State is unaffected.

## Timing
- Reset values: `sel`=00, state IDLE, `rr`=0, `pkt_cnt`=0, `err`=0. All grants are 0 because `sel`=00.
- HEAD arrival to `sel` asserted: 1 cycle. The HEAD itself is granted in the first LOCK cycle if `ordy`=1.
- Each accepted flit costs exactly one cycle while `ordy`=1 and the locked input is valid.
- A TAIL accepted at edge n puts `sel`=00 from edge n. This gives one IDLE bubble cycle; the next HEAD can lock at edge n+1.
- Back-to-back packets from both ports: grants alternate 0,1,0,… regardless of arrival order after the first.
- `ordy`=0 in LOCKx: grants are 0 and state is held. A TAIL held under `ordy`=0 does not release the lock.
- Simultaneous TAIL acceptance and new HEAD on the other port in the same cycle: the HEAD is seen next cycle in IDLE. There is no direct LOCK0→LOCK1 transition.
- Asynchronous reset mid-packet forces IDLE immediately. The upstream source must resend from HEAD.
- `pkt_cnt` at all-ones plus one TAIL gives 0. There is no saturation.

## Structure
- Shared defines (same header as the mux): `TYPEW`, TYPE_NONE, TYPE_HEAD, TYPE_DATA, TYPE_TAIL, `PORT` width, and the `Enable`/`Disable`/`Enable_`/`Disable_` levels. The arbiter state encoding also goes there.
- One optional sub-module: `rr_pick2`, a combinational two-request round-robin picker taking `rr`. It is reusable for a 4-input version later.
- The rest is a single always block for state/`sel`/`rr` plus the counter and error logic.

## Test plan
- Single packet on input 1: HEAD, 20 DATA, TAIL with `ordy`=1. Expect `sel`=10 one cycle after HEAD, 22 grants on `grant_1`, `sel`=00 after TAIL, `pkt_cnt`=1.
- Both HEADs in the same cycle after reset: input 0 served first. After its TAIL, one IDLE cycle, then `sel`=10, and `pkt_cnt`=2 at the end.
- `ordy` low for 3 cycles mid-packet on input 0: `grant_0`=0 for those cycles, `sel` holds 01, and no flit is lost or double-counted.
- DATA flit valid on input 1 while IDLE: `err`=1 next cycle, no grant, `sel` stays 00. `err` is still 1 after 10 further cycles.
- `rst_` asserted mid-packet while in LOCK1: `sel`=00, `pkt_cnt`=0, `err`=0 immediately. A new HEAD on input 0 after release locks LOCK0.
- `CNTW`=4, 17 single-flit-pair packets: `pkt_cnt` reads 1 after wrap.
